// File: rtl/ook_pkg.sv
// Shared OOK definitions: FSM states, DAC/ADC midscale level and accumulator sizing.
package ook_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } ook_state_e;

    // Idle level of the DDS OOK transmitter; offset-binary zero on the ADC side.
    localparam logic [7:0] OOK_MIDSCALE = 8'd128;

    function automatic int unsigned acc_width(input int unsigned bit_samples);
        return 8 + $clog2(bit_samples);
    endfunction

endpackage

// File: rtl/ook_demod_if.sv
// ADC sample input and recovered-bit output bundle for ook_demod.
interface ook_demod_if
    import ook_pkg::*;
#(
    parameter int unsigned BIT_SAMPLES = 16
);
    localparam int unsigned W = acc_width(BIT_SAMPLES);

    logic         adc_valid;
    logic [7:0]   adc_data;
    logic         bit_out;
    logic         bit_valid;
    logic         carrier_det;
    logic [W-1:0] acc_dbg;

    modport master (
        output adc_valid, adc_data,
        input  bit_out, bit_valid, carrier_det, acc_dbg
    );

    modport slave (
        input  adc_valid, adc_data,
        output bit_out, bit_valid, carrier_det, acc_dbg
    );

endinterface

// File: rtl/ook_integrator.sv
// Per-sample magnitude register plus bit-window accumulator, sample counter and window-done pulse.
module ook_integrator
    import ook_pkg::*;
#(
    parameter int unsigned BIT_SAMPLES = 16,
    localparam int unsigned W  = acc_width(BIT_SAMPLES),
    localparam int unsigned CW = $clog2(BIT_SAMPLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adc_valid,
    input  logic [7:0]   adc_data,
    input  logic         accept,
    output logic [7:0]   mag,
    output logic         mag_valid,
    output logic [W-1:0] sum,
    output logic         done
);

    logic [7:0]    mag_d;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;

    always_comb begin
        mag_d = '0;
        if (adc_data >= OOK_MIDSCALE) begin
            mag_d = adc_data - OOK_MIDSCALE;
        end else begin
            mag_d = OOK_MIDSCALE - adc_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag       <= '0;
            mag_valid <= 1'b0;
        end else begin
            mag_valid <= adc_valid;
            if (adc_valid) begin
                mag <= mag_d;
            end
        end
    end

    // sum already includes the sample being accepted, so it is the final total when done fires
    assign sum  = acc + W'(mag);
    assign done = accept && (cnt == CW'(BIT_SAMPLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ook_demod.sv
// OOK bit demodulator: integrate-and-dump over a bit period with HUNT/TRACK timing acquisition.
// Optional threshold hysteresis enabled by defining OOK_DEMOD_HYST_EN.
module ook_demod
    import ook_pkg::*;
#(
    parameter int unsigned BIT_SAMPLES = 16,
    parameter int unsigned THRESH      = 32,
    parameter int unsigned HYST        = 8,
    parameter int unsigned MAX_ZEROS   = 8
) (
    input logic        clk,
    input logic        rst,
    ook_demod_if.slave bus
);

    localparam int unsigned W = acc_width(BIT_SAMPLES);

    if ((BIT_SAMPLES & (BIT_SAMPLES - 1)) != 0 || BIT_SAMPLES < 4 || BIT_SAMPLES > 256
        || THRESH > 128 || HYST >= THRESH || MAX_ZEROS < 1 || MAX_ZEROS > 255) begin : g_bad_params
        $error("ook_demod: parameter out of range");
    end

`ifdef OOK_DEMOD_HYST_EN
    localparam logic [W-1:0] THR_RISE = W'((THRESH + HYST) * BIT_SAMPLES);
    localparam logic [W-1:0] THR_FALL = W'((THRESH - HYST) * BIT_SAMPLES);
    localparam logic [7:0]   HUNT_THR = 8'(THRESH + HYST);
    logic prev_bit;
`else
    localparam logic [W-1:0] THR      = W'(THRESH * BIT_SAMPLES);
    localparam logic [7:0]   HUNT_THR = 8'(THRESH);
`endif

    ook_state_e   state_q, state_d;
    logic [7:0]   zero_cnt;
    logic [7:0]   mag;
    logic         mag_valid;
    logic [W-1:0] sum;
    logic         done;
    logic         trigger;
    logic         accept;
    logic         decision;
    logic         drop;
    logic         bit_out_q;
    logic         bit_valid_q;
    logic [W-1:0] acc_dbg_q;

    ook_integrator #(
        .BIT_SAMPLES(BIT_SAMPLES)
    ) u_integrator (
        .clk       (clk),
        .rst       (rst),
        .adc_valid (bus.adc_valid),
        .adc_data  (bus.adc_data),
        .accept    (accept),
        .mag       (mag),
        .mag_valid (mag_valid),
        .sum       (sum),
        .done      (done)
    );

    // The triggering HUNT sample becomes sample 0 of the first window.
    always_comb begin
        trigger = mag_valid && (state_q == HUNT) && (mag >= HUNT_THR);
        accept  = mag_valid && ((state_q == TRACK) || trigger);
    end

    always_comb begin
        decision = 1'b0;
`ifdef OOK_DEMOD_HYST_EN
        decision = (sum >= (prev_bit ? THR_FALL : THR_RISE));
`else
        decision = (sum >= THR);
`endif
        drop    = done && !decision && (zero_cnt == 8'(MAX_ZEROS - 1));
        state_d = state_q;
        case (state_q)
            HUNT:    if (trigger) state_d = TRACK;
            TRACK:   if (drop)    state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            zero_cnt    <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            acc_dbg_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_valid_q <= done;
            if (done) begin
                bit_out_q <= decision;
                acc_dbg_q <= sum;
                if (decision || drop) begin
                    zero_cnt <= '0;
                end else begin
                    zero_cnt <= zero_cnt + 1'b1;
                end
            end
        end
    end

`ifdef OOK_DEMOD_HYST_EN
    // A drop is always a 0 decision, so HUNT entry leaves prev_bit cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_bit <= 1'b0;
        end else if (done) begin
            prev_bit <= decision;
        end
    end
`endif

    assign bus.bit_out     = bit_out_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.acc_dbg     = acc_dbg_q;
    assign bus.carrier_det = (state_q == TRACK);

endmodule
